// File: rtl/sn74ls122_sync.sv
// sn74ls122_sync
//   Clocked model of the 74LS122 retriggerable monostable with clear. A
//   qualified trigger edge produces an output pulse of exactly WIDTH clk
//   cycles. A trigger that arrives while the pulse is running restarts the
//   count, so the pulse stretches with no low gap.
//
//   Optional build macro SN74LS122_NORETRIG_EN: when it is defined, trigger
//   edges are ignored while the pulse is running. This gives a
//   non-retriggerable one-shot in the style of the '221.
//
// Parameters
//   WIDTH  pulse width in clk cycles (1..65535)
//   CNT_W  counter width; must satisfy 2**CNT_W > WIDTH
//
// Ports
//   clk    system clock, rising edge
//   rst    synchronous reset, active-high
//   a1_n   active-low trigger input A1
//   a2_n   active-low trigger input A2
//   b1     active-high trigger input B1
//   b2     active-high trigger input B2
//   clr_n  active-low clear
//   q      pulse output
//   q_n    complement of q
//
// State | meaning
// IDLE  | no pulse, q=0
// ACTIVE| pulse running, q=1, cnt holds the remaining cycles minus one

module sn74ls122_sync #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic a1_n,
  input  logic a2_n,
  input  logic b1,
  input  logic b2,
  input  logic clr_n,
  output logic q,
  output logic q_n
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             t_s_q, t_d_q, clr_s_q, clr_d_q;
  logic             trig_raw;
  logic             edge_fire, rel_fire, fire;

  assign trig_raw = (~a1_n | ~a2_n) & b1 & b2;

  // The trigger and clear history registers reset to 1. Inputs that are
  // already asserted when rst drops therefore look static and do not fire.
  always_ff @(posedge clk) begin
    if (rst) begin
      t_s_q   <= 1'b1;
      t_d_q   <= 1'b1;
      clr_s_q <= 1'b1;
      clr_d_q <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      t_s_q   <= trig_raw;
      t_d_q   <= t_s_q;
      clr_s_q <= clr_n;
      clr_d_q <= clr_s_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rel_fire = t_s_q & clr_s_q & ~clr_d_q;
`ifdef SN74LS122_NORETRIG_EN
    edge_fire = t_s_q & ~t_d_q & (state_q == IDLE);
`else
    edge_fire = t_s_q & ~t_d_q;
`endif
    fire = clr_s_q & (edge_fire | rel_fire);

    if (!clr_s_q) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (fire) begin
      // A fire always reloads the count, even when it lands on the
      // terminal cycle of a running pulse, so q never drops between pulses.
      state_d = ACTIVE;
      cnt_d   = RELOAD;
    end else if (state_q == ACTIVE) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        state_d = IDLE;
      end
    end
  end

  assign q   = (state_q == ACTIVE);
  assign q_n = ~q;

endmodule

// File: tb/tb_sn74ls122_sync.sv
module tb_sn74ls122_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, a1_n, a2_n, b1, b2, clr_n;
  logic q4, qn4, q8, qn8, q16, qn16, q1, qn1;

`ifdef SN74LS122_NORETRIG_EN
  localparam bit NR = 1'b1;
`else
  localparam bit NR = 1'b0;
`endif

  sn74ls122_sync #(.WIDTH(4), .CNT_W(16)) dut4 (
    .clk(clk), .rst(rst), .a1_n(a1_n), .a2_n(a2_n), .b1(b1), .b2(b2),
    .clr_n(clr_n), .q(q4), .q_n(qn4));
  sn74ls122_sync #(.WIDTH(8), .CNT_W(16)) dut8 (
    .clk(clk), .rst(rst), .a1_n(a1_n), .a2_n(a2_n), .b1(b1), .b2(b2),
    .clr_n(clr_n), .q(q8), .q_n(qn8));
  sn74ls122_sync #(.WIDTH(16), .CNT_W(16)) dut16 (
    .clk(clk), .rst(rst), .a1_n(a1_n), .a2_n(a2_n), .b1(b1), .b2(b2),
    .clr_n(clr_n), .q(q16), .q_n(qn16));
  sn74ls122_sync #(.WIDTH(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .a1_n(a1_n), .a2_n(a2_n), .b1(b1), .b2(b2),
    .clr_n(clr_n), .q(q1), .q_n(qn1));

  // sel: 0 = WIDTH 4, 1 = WIDTH 8, 2 = WIDTH 16, 3 = WIDTH 1
  typedef struct {
    string name;
    logic  rst, a1_n, a2_n, b1, b2, clr_n;
    int    sel;
    logic  exp_q;
    bit    chk_cnt;
    int    exp_cnt;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic add(input string nm, input logic r, input logic a1, input logic a2,
                     input logic bb1, input logic bb2, input logic c, input int s,
                     input logic e, input bit cc = 1'b0, input int ec = 0);
    vec_t v;
    v.name = nm; v.rst = r; v.a1_n = a1; v.a2_n = a2; v.b1 = bb1; v.b2 = bb2;
    v.clr_n = c; v.sel = s; v.exp_q = e; v.chk_cnt = cc; v.exp_cnt = ec;
    vecs.push_back(v);
  endtask

  function automatic logic get_q(input int s);
    case (s)
      0: return q4;
      1: return q8;
      2: return q16;
      default: return q1;
    endcase
  endfunction

  function automatic logic get_qn(input int s);
    case (s)
      0: return qn4;
      1: return qn8;
      2: return qn16;
      default: return qn1;
    endcase
  endfunction

  function automatic int get_cnt(input int s);
    case (s)
      0: return int'(dut4.cnt_q);
      1: return int'(dut8.cnt_q);
      2: return int'(dut16.cnt_q);
      default: return int'(dut1.cnt_q);
    endcase
  endfunction

  task automatic check(input string nm, input int idx, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row %0d: got %b expected %b", nm, idx, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; a1_n = 1'b1; a2_n = 1'b1; b1 = 1'b0; b2 = 1'b1; clr_n = 1'b1;

    // A: basic pulse, WIDTH 4. The trigger is sampled at row 1, fires at
    // row 2, and q is high for rows 2..5.
    add("A_rst", 1, 0,1,0,1,1, 0, 0);
    add("A",     0, 0,1,0,1,1, 0, 0);
    add("A",     0, 0,1,1,1,1, 0, 0);
    add("A",     0, 0,1,1,1,1, 0, 1, 1, 3);
    add("A",     0, 0,1,1,1,1, 0, 1, 1, 2);
    add("A",     0, 0,1,1,1,1, 0, 1);
    add("A",     0, 0,1,1,1,1, 0, 1, 1, 0);
    add("A",     0, 0,1,1,1,1, 0, 0);
    add("A",     0, 0,1,1,1,1, 0, 0);

    // B: retrigger 3 cycles after the first fire, WIDTH 4. Retriggerable
    // gives 7 high cycles; non-retriggerable gives 4.
    add("B_rst", 1, 0,1,0,1,1, 0, 0);
    add("B",     0, 0,1,0,1,1, 0, 0);
    add("B",     0, 0,1,1,1,1, 0, 0);
    add("B",     0, 0,1,0,1,1, 0, 1);
    add("B",     0, 0,1,0,1,1, 0, 1);
    add("B",     0, 0,1,1,1,1, 0, 1);
    add("B",     0, 0,1,1,1,1, 0, 1, 1, NR ? 0 : 3);
    add("B",     0, 0,1,1,1,1, 0, NR ? 1'b0 : 1'b1);
    add("B",     0, 0,1,1,1,1, 0, NR ? 1'b0 : 1'b1);
    add("B",     0, 0,1,1,1,1, 0, NR ? 1'b0 : 1'b1);
    add("B",     0, 0,1,1,1,1, 0, 0);

    // C: clear mid-pulse, WIDTH 8, then release while the trigger is held.
    add("C_rst", 1, 1,0,0,1,1, 1, 0);
    add("C",     0, 1,0,0,1,1, 1, 0);
    add("C",     0, 1,0,1,1,1, 1, 0);
    add("C",     0, 1,0,1,1,1, 1, 1, 1, 7);
    add("C",     0, 1,0,1,1,1, 1, 1);
    add("C",     0, 1,0,1,1,1, 1, 1);
    add("C",     0, 1,0,1,1,0, 1, 1);
    add("C",     0, 1,0,1,1,0, 1, 0, 1, 0);
    add("C",     0, 1,0,1,1,0, 1, 0);
    add("C",     0, 1,0,1,1,1, 1, 0);
    for (int k = 0; k < 8; k++) add("C_rel", 0, 1,0,1,1,1, 1, 1);
    add("C",     0, 1,0,1,1,1, 1, 0);
    add("C",     0, 1,0,1,1,1, 1, 0);

    // D: trigger held across reset must not fire; toggling b2 gives one pulse.
    add("D_rst", 1, 0,1,1,1,1, 0, 0);
    add("D_rst", 1, 0,1,1,1,1, 0, 0);
    for (int k = 0; k < 6; k++) add("D_static", 0, 0,1,1,1,1, 0, 0);
    add("D",     0, 0,1,1,0,1, 0, 0);
    add("D",     0, 0,1,1,1,1, 0, 0);
    for (int k = 0; k < 4; k++) add("D_pulse", 0, 0,1,1,1,1, 0, 1);
    add("D",     0, 0,1,1,1,1, 0, 0);
    add("D",     0, 0,1,1,1,1, 0, 0);

    // E: reset mid-pulse, WIDTH 16, asserted when cnt is 10.
    add("E_rst", 1, 0,1,0,1,1, 2, 0);
    add("E",     0, 0,1,0,1,1, 2, 0);
    add("E",     0, 0,1,1,1,1, 2, 0);
    add("E",     0, 0,1,1,1,1, 2, 1, 1, 15);
    for (int k = 0; k < 4; k++) add("E", 0, 0,1,1,1,1, 2, 1);
    add("E",     0, 0,1,1,1,1, 2, 1, 1, 10);
    add("E_rst", 1, 0,1,1,1,1, 2, 0, 1, 0);
    for (int k = 0; k < 4; k++) add("E_after", 0, 0,1,1,1,1, 2, 0, 1, 0);

    // F: WIDTH 1 with b1 toggling every cycle.
    add("F_rst", 1, 0,1,0,1,1, 3, 0);
    add("F",     0, 0,1,0,1,1, 3, 0);
    add("F",     0, 0,1,1,1,1, 3, 0);
    add("F",     0, 0,1,0,1,1, 3, 1);
    add("F",     0, 0,1,1,1,1, 3, 0);
    add("F",     0, 0,1,0,1,1, 3, 1);
    add("F",     0, 0,1,1,1,1, 3, 0);
    add("F",     0, 0,1,0,1,1, 3, 1);
    add("F",     0, 0,1,0,1,1, 3, 0);
    add("F",     0, 0,1,0,1,1, 3, 0);

    // G: a fire that lands exactly on cnt==0 reloads the count, WIDTH 4.
    add("G_rst", 1, 0,1,0,1,1, 0, 0);
    add("G",     0, 0,1,0,1,1, 0, 0);
    add("G",     0, 0,1,1,1,1, 0, 0);
    add("G",     0, 0,1,0,1,1, 0, 1, 1, 3);
    add("G",     0, 0,1,0,1,1, 0, 1);
    add("G",     0, 0,1,0,1,1, 0, 1);
    add("G",     0, 0,1,1,1,1, 0, 1, 1, 0);
    add("G",     0, 0,1,1,1,1, 0, NR ? 1'b0 : 1'b1, 1, NR ? 0 : 3);
    add("G",     0, 0,1,1,1,1, 0, NR ? 1'b0 : 1'b1);
    add("G",     0, 0,1,1,1,1, 0, NR ? 1'b0 : 1'b1);
    add("G",     0, 0,1,1,1,1, 0, NR ? 1'b0 : 1'b1, 1, 0);
    add("G",     0, 0,1,1,1,1, 0, 0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; a1_n = vecs[i].a1_n; a2_n = vecs[i].a2_n;
      b1 = vecs[i].b1; b2 = vecs[i].b2; clr_n = vecs[i].clr_n;
      @(posedge clk);
      #1;
      check({vecs[i].name, " q"}, i, get_q(vecs[i].sel), vecs[i].exp_q);
      check({vecs[i].name, " q_n"}, i, get_qn(vecs[i].sel), ~vecs[i].exp_q);
      if (vecs[i].chk_cnt) begin
        checks++;
        if (get_cnt(vecs[i].sel) != vecs[i].exp_cnt) begin
          failures++;
          $display("FAIL %s cnt row %0d: got %0d expected %0d",
                   vecs[i].name, i, get_cnt(vecs[i].sel), vecs[i].exp_cnt);
        end
      end
      if (vecs[i].rst) begin
        for (int s = 0; s < 4; s++) begin
          check("reset q", i, get_q(s), 1'b0);
          check("reset q_n", i, get_qn(s), 1'b1);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sn74ls122_sync.md
Name: sn74ls122_sync

Overview:
- Clocked, synthesizable model of the 74LS122 retriggerable monostable (one-shot) with clear.
- Combinational gates such as the Schmitt NAND clean up an input edge. This block works the other way round: it turns a trigger edge into a clean output pulse of fixed, controlled width.
- Pulse width is set in clock cycles rather than by an external RC network.
- Intended as the pulse-generating end of TTL-model testbenches and for FPGA use of board designs that contain a '122.

Parameters:
- WIDTH, 16, output pulse width in clk cycles; legal range 1..65535.
- CNT_W, 16, counter width in bits; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- a1_n  input  1  active-low trigger input A1.
- a2_n  input  1  active-low trigger input A2.
- b1  input  1  active-high trigger input B1.
- b2  input  1  active-high trigger input B2.
- clr_n  input  1  active-low clear.
- q  output  1  pulse output.
- q_n  output  1  complement of q; always exactly ~q.

Behaviour:
- Input stage: a1_n, a2_n, b1, b2 and clr_n are registered once on every clk edge. All decisions use the registered values only.
- Trigger term: t = (~a1_n | ~a2_n) & b1 & b2. t_s is the registered t. t_d is t_s delayed by one cycle.
- Clear term: clr_s is the registered clr_n. clr_d is clr_s delayed by one cycle.
- Fire condition (evaluated each cycle): fire = clr_s & ((t_s & ~t_d) | (t_s & clr_s & ~clr_d)).
  - The first term is a trigger rising edge.
  - The second term is release of clear while t is already true, matching '122 behaviour.
- States: IDLE (q=0) and ACTIVE (q=1), held as q plus a down-counter cnt[CNT_W-1:0].
- Transition on fire, from either state: next edge sets q=1 and cnt=WIDTH-1.
- In ACTIVE with no fire:
  - cnt>0 → cnt decrements.
  - cnt==0 → next edge sets q=0 (IDLE).
- Resulting pulse: q is high for exactly WIDTH cycles after the last fire.
- Latency: input change to q rising is 2 clk edges (input register, then state update).
- Retrigger: fire while ACTIVE reloads cnt=WIDTH-1, stretching the pulse to WIDTH cycles after that fire. No low gap appears.
- Clear: clr_s=0 → next edge q=0 and cnt=0, regardless of fire or count. Clear has priority over everything except rst.
- Clear mid-pulse: the pulse ends one cycle after clr_s falls. On release, the block re-fires only if t_s=1 at the release edge.
- Reset values:
  - q=0, q_n=1, cnt=0.
  - t_s=t_d=1 and clr_s=clr_d=1, so inputs already in the trigger state when rst deasserts do not fire.
- Reset mid-pulse: the pulse terminates on the next edge.
- Simultaneous fire and cnt==0: fire wins; q stays high and reloads.
- WIDTH=1: a single-cycle pulse. Back-to-back fires can only occur every 2 cycles because of edge detection, so q toggles 1,0,1.
- Static inputs: a constant t=1 produces exactly one pulse. A new pulse needs t to fall and rise again.

Optional Feature:
- Macro: SN74LS122_NORETRIG_EN.
- Defined: the block models a non-retriggerable one-shot ('221-style).
  - Trigger-edge fire is ignored while ACTIVE, so the pulse is exactly WIDTH cycles from the first fire.
  - Clear-release fire behaves as before, since q=0 at that point.
- Undefined: retriggerable behaviour as specified above.

Test Plan:
- WIDTH=4, a1_n=0, b2=1, b1 rises 0→1 at edge k → q=1 at edges k+2..k+5, q=0 at k+6; q_n is always the inverse.
- WIDTH=4, second b1 rising edge 3 cycles after the first → q stays high continuously and falls 4 cycles after the second fire (7 high cycles total). With SN74LS122_NORETRIG_EN: exactly 4 high cycles.
- WIDTH=8, clr_n driven low 3 cycles into the pulse → q falls 2 edges after clr_n falls. Releasing clr_n with b1=b2=1 and a2_n=0 → a new 8-cycle pulse starts 2 edges after release.
- Inputs held in the trigger state (a1_n=0, b1=b2=1) across rst assert and deassert → q stays 0 indefinitely. Then b2 toggles 1→0→1 → one WIDTH pulse.
- rst asserted mid-pulse with WIDTH=16 and cnt=10 → q=0 and cnt=0 on the next edge. No pulse after rst deasserts while inputs are static.
- WIDTH=1, b1 toggling every cycle with a1_n=0, b2=1 → q pattern 1,0,1,0 aligned 2 edges after each b1 rise.
